uart_rx_param: RTL and testbench

Parametrised UART receiver: oversampled serial input, configurable frame format, per-word error flags, and a one-word output buffer with valid/ready handshake. It is the receive side of the UART datapath. It deserialises the asynchronous line into parallel words for the downstream consumer and reports parity, framing, break and overrun conditions.

---
 rtl/uart_rx_param.sv | 276 +++++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with a configurable frame format,
// per-word parity/frame/break flags, a sticky overrun flag, and a one-word
// output buffer drained through a valid/ready handshake.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_Serial,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  input  logic                 Rx_Ready,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Break,
  output logic                 Overrun
);

  // Bit-period counter width and the sample points inside one bit period.
  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_C  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1'b1);
  localparam logic [3:0]    DLAST_C = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SLAST_C = 4'(STOP_BITS - 1);
  localparam logic [1:0]    PMODE_C = 2'(PARITY);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_e;

  // Parity check of a received word against its parity bit for the
  // configured mode; no parity never reports an error.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit);
    logic odd_ones;
    odd_ones = (^data) ^ pbit;
    case (PMODE_C)
      2'd1:    parity_error = odd_ones;
      2'd2:    parity_error = ~odd_ones;
      default: parity_error = 1'b0;
    endcase
  endfunction

  // A break is a frame that was low from start bit through the stop bits:
  // zero data, zero parity bit (when present) and a framing error.
  function automatic logic break_detect(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit,
                                        input logic                 ferr);
    break_detect = ferr & (data == '0) & ((PMODE_C == 2'd0) | ~pbit);
  endfunction

  // Synchroniser and receive FSM state.
  logic [1:0]           sync_q;
  logic                 rxs_s;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_err_q, stop_err_d;
  logic                 stop_err_s;
  logic                 done_s;
  logic                 done_fe_s;

  // Output buffer state.
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 brk_q, brk_d;
  logic                 ovr_q, ovr_d;
  logic                 handshake_s;

  assign rxs_s       = sync_q[1];
  assign handshake_s = valid_q & Rx_Ready;

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], Rx_Serial};
    end
  end

  // Receive FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_err_q <= stop_err_d;
    end
  end

  // Next-state logic: start validation at mid-bit, then one sample per bit
  // period at the middle of each data, parity and stop bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + ONE_C;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_err_d = stop_err_q;
    stop_err_s = stop_err_q | ~rxs_s;
    done_s     = 1'b0;
    done_fe_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        bit_d      = 4'd0;
        stop_err_d = 1'b0;
        if (!rxs_s) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = '0;
          bit_d = 4'd0;
          // A line that is high again at mid-start was only a glitch.
          if (rxs_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          shift_d = {rxs_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == DLAST_C) begin
            bit_d = 4'd0;
            if (PMODE_C != 2'd0) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          bit_d   = 4'd0;
          par_d   = rxs_s;
          state_d = S_STOP;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d      = '0;
          stop_err_d = stop_err_s;
          if (bit_q == SLAST_C) begin
            done_s    = 1'b1;
            done_fe_s = stop_err_s;
            bit_d     = 4'd0;
            // After a framing error wait for the line to go idle so a held
            // break does not immediately look like a new start bit.
            if (stop_err_s) begin
              state_d = S_WAIT_HIGH;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rxs_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_HIGH;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
      ovr_q     <= ovr_d;
    end
  end

  // Buffer update: load a completed word when the slot is free or being
  // drained this cycle, otherwise drop it and flag overrun; a handshake
  // clears valid and the sticky overrun.
  always_comb begin
    rx_data_d = rx_data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    ovr_d     = ovr_q;
    if (done_s) begin
      if (!valid_q || Rx_Ready) begin
        rx_data_d = shift_q;
        perr_d    = parity_error(shift_q, par_q);
        ferr_d    = done_fe_s;
        brk_d     = break_detect(shift_q, par_q, done_fe_s);
        valid_d   = 1'b1;
        if (handshake_s) begin
          ovr_d = 1'b0;
        end else begin
          ovr_d = ovr_q;
        end
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake_s) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      valid_d = valid_q;
      ovr_d   = ovr_q;
    end
  end

  assign Rx_Data    = rx_data_q;
  assign Rx_Valid   = valid_q;
  assign Parity_Err = perr_q;
  assign Frame_Err  = ferr_q;
  assign Break      = brk_q;
  assign Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param: four receivers with different frame formats,
// directed scenarios plus random frames, checked against a frame-level model.
module tb_uart_rx_param;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] line = 4'b1111;
  logic [3:0] rdy  = 4'b1111;

  logic [7:0] d0, d1, d2;
  logic [4:0] d3;
  logic v0, v1, v2, v3;
  logic pe0, pe1, pe2, pe3;
  logic fe0, fe1, fe2, fe3;
  logic brk0, brk1, brk2, brk3;
  logic ovr0, ovr1, ovr2, ovr3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise0 = 0;
  int vcnt0 = 0;
  logic pv0 = 1'b0;

  // Entries: {dut index[1:0], break, frame_err, parity_err, data[8:0]}
  logic [13:0] got_q[$];
  logic [13:0] exp_q[$];

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .Rx_Serial(line[0]), .Rx_Data(d0), .Rx_Valid(v0),
    .Rx_Ready(rdy[0]), .Parity_Err(pe0), .Frame_Err(fe0), .Break(brk0), .Overrun(ovr0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .Rx_Serial(line[1]), .Rx_Data(d1), .Rx_Valid(v1),
    .Rx_Ready(rdy[1]), .Parity_Err(pe1), .Frame_Err(fe1), .Break(brk1), .Overrun(ovr1));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .Rx_Serial(line[2]), .Rx_Data(d2), .Rx_Valid(v2),
    .Rx_Ready(rdy[2]), .Parity_Err(pe2), .Frame_Err(fe2), .Break(brk2), .Overrun(ovr2));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .Rx_Serial(line[3]), .Rx_Data(d3), .Rx_Valid(v3),
    .Rx_Ready(rdy[3]), .Parity_Err(pe3), .Frame_Err(fe3), .Break(brk3), .Overrun(ovr3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every consumed word and track the valid pulse of u0.
  always @(negedge clk) begin
    if (v0 && !pv0) rise0 <= cyc;
    pv0 <= v0;
    if (v0) vcnt0 <= vcnt0 + 1;
    if (v0 && rdy[0]) got_q.push_back({2'd0, brk0, fe0, pe0, 1'b0, d0});
    if (v1 && rdy[1]) got_q.push_back({2'd1, brk1, fe1, pe1, 1'b0, d1});
    if (v2 && rdy[2]) got_q.push_back({2'd2, brk2, fe2, pe2, 1'b0, d2});
    if (v3 && rdy[3]) got_q.push_back({2'd3, brk3, fe3, pe3, 4'd0, d3});
  end

  // Frame-level reference: what the receiver must report for a frame.
  function automatic logic [13:0] model(input int idx, input int dbits, input logic [8:0] data,
                                        input int pmode, input logic pbit, input int nstop,
                                        input logic [1:0] stops);
    logic [8:0] d;
    int ones;
    logic pe, fe, brk;
    d    = data & 9'((1 << dbits) - 1);
    ones = $countones(d) + ((pmode != 0 && pbit) ? 1 : 0);
    pe   = (pmode == 1) ? (ones % 2 == 1) : (pmode == 2) ? (ones % 2 == 0) : 1'b0;
    fe   = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    brk  = fe && (d == 9'd0) && (pmode == 0 || pbit == 1'b0);
    return {idx[1:0], brk, fe, pe, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one frame on line[idx], one bit every CPB cycles, then idle high.
  task automatic frame(input int idx, input logic [8:0] data, input logic pbit,
                       input logic [1:0] stops, input bit record);
    int dbits, pmode, nstop;
    logic bq[$];
    dbits = (idx == 3) ? 5 : 8;
    pmode = (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
    nstop = (idx == 3) ? 2 : 1;
    if (record) exp_q.push_back(model(idx, dbits, data, pmode, pbit, nstop, stops));
    bq.push_back(1'b0);
    for (int i = 0; i < dbits; i++) bq.push_back(data[i]);
    if (pmode != 0) bq.push_back(pbit);
    for (int i = 0; i < nstop; i++) bq.push_back(stops[i]);
    @(posedge clk); #1;
    start_cyc = cyc;
    foreach (bq[i]) begin
      line[idx] = bq[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    line[idx] = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_sb(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      chk(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int base, lat, exp_lat, idx;
    logic [1:0] st;

    settle(5);
    rst = 1'b0;
    settle(2);

    // Reset state.
    chk("rst_data", 32'(d0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_perr", 32'(pe0), 32'd0);
    chk("rst_ferr", 32'(fe0), 32'd0);
    chk("rst_break", 32'(brk0), 32'd0);
    chk("rst_ovr", 32'(ovr0), 32'd0);

    // 8N1 0x55 with Ready high: one-cycle pulse at the expected latency.
    base = vcnt0;
    frame(0, 9'h055, 1'b0, 2'b11, 1'b1);
    settle(40);
    exp_lat = 2 + 1 + CPB / 2 + (8 + 0 + 1) * CPB + 1;
    lat = rise0 - start_cyc;
    checks++;
    assert (lat >= exp_lat - 1 && lat <= exp_lat + 1) else begin
      errors++;
      $error("FAIL latency: observed %0d expected %0d +/-1", lat, exp_lat);
    end
    chk("pulse_width", 32'(vcnt0 - base), 32'd1);
    check_sb("basic_55");

    // Even and odd parity, correct and wrong parity bits.
    frame(1, 9'h0A3, 1'b0, 2'b11, 1'b1);
    frame(1, 9'h0A3, 1'b1, 2'b11, 1'b1);
    frame(2, 9'h0A3, 1'b0, 2'b11, 1'b1);
    frame(2, 9'h0A3, 1'b1, 2'b11, 1'b1);
    settle(40);
    check_sb("parity");

    // Overrun: three words with Ready low, only the first is held.
    rdy[0] = 1'b0;
    frame(0, 9'h011, 1'b0, 2'b11, 1'b1);
    frame(0, 9'h022, 1'b0, 2'b11, 1'b0);
    frame(0, 9'h033, 1'b0, 2'b11, 1'b0);
    settle(40);
    chk("ovr_valid", 32'(v0), 32'd1);
    chk("ovr_data", 32'(d0), 32'h11);
    chk("ovr_flag", 32'(ovr0), 32'd1);
    rdy[0] = 1'b1;
    settle(1);
    rdy[0] = 1'b0;
    chk("ovr_after_hs_valid", 32'(v0), 32'd0);
    chk("ovr_after_hs_flag", 32'(ovr0), 32'd0);
    settle(200);
    chk("ovr_nothing_pending", 32'(v0), 32'd0);
    rdy[0] = 1'b1;
    check_sb("overrun");

    // Framing error, then a line held low for three frame times.
    frame(0, 9'h03C, 1'b0, 2'b00, 1'b1);
    settle(40);
    check_sb("frame_err");
    exp_q.push_back(model(0, 8, 9'h000, 0, 1'b0, 1, 2'b00));
    line[0] = 1'b0;
    repeat (3 * 10 * CPB) @(posedge clk);
    #1;
    line[0] = 1'b1;
    settle(40);
    check_sb("break");

    // Short low glitch produces nothing.
    line[0] = 1'b0;
    settle(CPB / 4);
    line[0] = 1'b1;
    settle(200);
    chk("glitch_valid", 32'(v0), 32'd0);
    check_sb("glitch");

    // Reset in the middle of the data bits discards the partial frame.
    fork
      frame(0, 9'h0FF, 1'b0, 2'b11, 1'b0);
      begin
        settle(60);
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
      end
    join
    settle(20);
    chk("midrst_valid", 32'(v0), 32'd0);
    chk("midrst_ferr", 32'(fe0), 32'd0);
    chk("midrst_break", 32'(brk0), 32'd0);
    frame(0, 9'h07E, 1'b0, 2'b11, 1'b1);
    settle(40);
    check_sb("after_reset");

    // Five data bits, two stop bits, back to back.
    frame(3, 9'h01F, 1'b0, 2'b11, 1'b1);
    frame(3, 9'h000, 1'b0, 2'b11, 1'b1);
    settle(60);
    check_sb("five_two");

    // Random frames across all formats, occasionally with bad stop bits.
    for (int n = 0; n < 24; n++) begin
      idx = $urandom_range(0, 3);
      st  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      frame(idx, 9'($urandom), 1'($urandom), st, 1'b1);
      settle($urandom_range(2, 20));
    end
    settle(60);
    check_sb("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
